// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: memory-op encodings, byte-count lookup
// and the access FSM state encoding.
package mem_access_pkg;

  typedef enum logic [4:0] {
    MEM_NONE = 5'd0,
    MEM_LB   = 5'd1,
    MEM_LH   = 5'd2,
    MEM_LW   = 5'd3,
    MEM_LBU  = 5'd4,
    MEM_LHU  = 5'd5,
    MEM_SB   = 5'd6,
    MEM_SH   = 5'd7,
    MEM_SW   = 5'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT_LAST,
    ST_DONE
  } state_e;

  // Number of bytes moved by an op; zero marks a non-memory op.
  function automatic logic [2:0] byte_count(logic [4:0] op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return 3'd1;
      MEM_LH, MEM_LHU, MEM_SH: return 3'd2;
      MEM_LW, MEM_SW:          return 3'd4;
      default:                 return 3'd0;
    endcase
  endfunction

  function automatic logic is_load(logic [4:0] op);
    return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
           (op == MEM_LBU) || (op == MEM_LHU);
  endfunction

  function automatic logic is_store(logic [4:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

endpackage

// File: rtl/mem_access_load_ext.sv
// Load-data extension: turns the assembled little-endian bytes into the
// 32-bit register value for the given load op.
module mem_load_ext
  import mem_access_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [31:0] raw,
  output logic [31:0] result
);

  always_comb begin
    case (op)
      MEM_LB:  result = {{24{raw[7]}}, raw[7:0]};
      MEM_LH:  result = {{16{raw[15]}}, raw[15:0]};
      MEM_LBU: result = {24'd0, raw[7:0]};
      MEM_LHU: result = {16'd0, raw[15:0]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: byte-serial loads/stores over the shared memory bus, stall
// generation, and a registered one-cycle write-back record.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int OP_W   = 5,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [OP_W-1:0]   op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              rd_en_i,
  input  logic [31:0]       rd_data_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic [7:0]        mem_dout_o,
  input  logic [7:0]        mem_din_i,
  input  logic              mem_gnt_i,
  output logic              stall_req_o,
  output logic              wb_valid_o,
  output logic              wb_rd_en_o,
  output logic [4:0]        wb_rd_addr_o,
  output logic [31:0]       wb_data_o
);

  state_e state_reg, state_next;

  logic [4:0]        op_in;
  logic [4:0]        op_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [4:0]        rd_addr_reg;
  logic              rd_en_reg;
  logic [2:0]        n_reg, k_reg;
  logic [31:0]       buf_reg, buf_merged, ext_data;
  logic              cap_pend_reg;
  logic [1:0]        cap_idx_reg;
  logic              wb_valid_reg, wb_rd_en_reg;
  logic [4:0]        wb_rd_addr_reg;
  logic [31:0]       wb_data_reg;
  logic              accept_mem, last_grant, op_is_load;

  assign op_in      = 5'(op_i);
  assign accept_mem = valid_i && (byte_count(op_in) != 3'd0);
  assign op_is_load = is_load(op_reg);
  assign last_grant = mem_gnt_i && (k_reg == n_reg - 3'd1);

  // Read data lags its grant by one cycle; fold the pending byte in here so
  // WAIT_LAST can extend the complete word in the same cycle it arrives.
  for (genvar gi = 0; gi < 4; gi++) begin : g_cap
    assign buf_merged[8*gi +: 8] = (cap_pend_reg && cap_idx_reg == 2'(gi)) ?
                                   mem_din_i : buf_reg[8*gi +: 8];
  end

  mem_load_ext u_load_ext (
    .op     (op_reg),
    .raw    (buf_merged),
    .result (ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:      if (accept_mem) state_next = ST_ACCESS;
      ST_ACCESS:    if (last_grant) state_next = op_is_load ? ST_WAIT_LAST : ST_DONE;
      ST_WAIT_LAST: state_next = ST_DONE;
      ST_DONE:      state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_a_o     = '0;
    mem_dout_o  = 8'd0;
    stall_req_o = 1'b0;
    case (state_reg)
      ST_IDLE:   stall_req_o = accept_mem;
      ST_ACCESS: begin
        mem_req_o   = 1'b1;
        mem_we_o    = is_store(op_reg);
        mem_a_o     = addr_reg + ADDR_W'(k_reg);
        mem_dout_o  = is_store(op_reg) ? wdata_reg[{k_reg[1:0], 3'b000} +: 8] : 8'd0;
        stall_req_o = 1'b1;
      end
      ST_WAIT_LAST: stall_req_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg         <= 5'd0;
      addr_reg       <= '0;
      wdata_reg      <= 32'd0;
      rd_addr_reg    <= 5'd0;
      rd_en_reg      <= 1'b0;
      n_reg          <= 3'd0;
      k_reg          <= 3'd0;
      buf_reg        <= 32'd0;
      cap_pend_reg   <= 1'b0;
      cap_idx_reg    <= 2'd0;
      wb_valid_reg   <= 1'b0;
      wb_rd_en_reg   <= 1'b0;
      wb_rd_addr_reg <= 5'd0;
      wb_data_reg    <= 32'd0;
    end else begin
      buf_reg        <= buf_merged;
      cap_pend_reg   <= 1'b0;
      wb_valid_reg   <= 1'b0;
      wb_rd_en_reg   <= 1'b0;
      wb_rd_addr_reg <= 5'd0;
      wb_data_reg    <= 32'd0;
      case (state_reg)
        ST_IDLE: if (valid_i) begin
          if (accept_mem) begin
            op_reg      <= op_in;
            addr_reg    <= addr_i;
            wdata_reg   <= wdata_i;
            rd_addr_reg <= rd_addr_i;
            rd_en_reg   <= rd_en_i;
            n_reg       <= byte_count(op_in);
            k_reg       <= 3'd0;
            buf_reg     <= 32'd0;
          end else begin
            wb_valid_reg   <= 1'b1;
            wb_rd_en_reg   <= rd_en_i;
            wb_rd_addr_reg <= rd_addr_i;
            wb_data_reg    <= rd_data_i;
          end
        end
        ST_ACCESS: if (mem_gnt_i) begin
          k_reg <= k_reg + 3'd1;
          if (op_is_load) begin
            cap_pend_reg <= 1'b1;
            cap_idx_reg  <= k_reg[1:0];
          end else if (last_grant) begin
            wb_valid_reg   <= 1'b1;
            wb_rd_addr_reg <= rd_addr_reg;
          end
        end
        ST_WAIT_LAST: begin
          wb_valid_reg   <= 1'b1;
          wb_rd_en_reg   <= rd_en_reg;
          wb_rd_addr_reg <= rd_addr_reg;
          wb_data_reg    <= ext_data;
        end
        default: ;
      endcase
    end
  end

  assign wb_valid_o   = wb_valid_reg;
  assign wb_rd_en_o   = wb_rd_en_reg;
  assign wb_rd_addr_o = wb_rd_addr_reg;
  assign wb_data_o    = wb_data_reg;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: the bench plays the memory/arbiter and checks every
// cycle against a transaction-level model of the expected bus and write-back.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [4:0]  op_i;
  logic [31:0] addr_i, wdata_i, rd_data_i;
  logic [4:0]  rd_addr_i;
  logic        rd_en_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_a_o;
  logic [7:0]  mem_dout_o, mem_din_i;
  logic        mem_gnt_i;
  logic        stall_req_o, wb_valid_o, wb_rd_en_o;
  logic [4:0]  wb_rd_addr_o;
  logic [31:0] wb_data_o;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .op_i(op_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rd_addr_i(rd_addr_i), .rd_en_i(rd_en_i), .rd_data_i(rd_data_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_a_o(mem_a_o),
    .mem_dout_o(mem_dout_o), .mem_din_i(mem_din_i), .mem_gnt_i(mem_gnt_i),
    .stall_req_o(stall_req_o), .wb_valid_o(wb_valid_o), .wb_rd_en_o(wb_rd_en_o),
    .wb_rd_addr_o(wb_rd_addr_o), .wb_data_o(wb_data_o)
  );

  typedef struct {
    logic [31:0] a;
    logic        we;
    logic [7:0]  d;
  } xfer_t;

  int checks = 0, failures = 0, cyc = 0;
  logic [7:0] mem [bit [31:0]];

  // Model of the outstanding transaction
  bit          active, is_mem, is_ld;
  int          t0, last_g, wb_cyc, gmode;
  xfer_t       xq[$];
  logic [31:0] exp_wb_data;
  logic [4:0]  exp_wb_rd;
  logic        exp_wb_en;
  bit          rd_pend;
  logic [31:0] rd_pend_addr;

  // Observations of the last transaction, used by the literal pins
  int          obs_wb_rel, obs_n;
  logic [31:0] obs_wb_data;
  logic        obs_wb_en;
  logic [4:0]  obs_wb_rd;
  logic [31:0] obs_a[8];
  logic [7:0]  obs_d[8];
  int          obs_rel[8];
  bit          stall_seen;

  function automatic logic [7:0] mem_rd(logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic int nb(logic [4:0] op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return 1;
      MEM_LH, MEM_LHU, MEM_SH: return 2;
      MEM_LW, MEM_SW:          return 4;
      default:                 return 0;
    endcase
  endfunction

  function automatic bit op_load(logic [4:0] op);
    return op == MEM_LB || op == MEM_LH || op == MEM_LW || op == MEM_LBU || op == MEM_LHU;
  endfunction

  // Sign/zero extension expressed as integer arithmetic on the raw value
  function automatic logic [31:0] ext_model(logic [4:0] op, logic [31:0] raw);
    longint v;
    case (op)
      MEM_LB:  begin v = longint'(raw) % 256;   if (v >= 128)   v = v - 256;   end
      MEM_LH:  begin v = longint'(raw) % 65536; if (v >= 32768) v = v - 65536; end
      MEM_LBU: v = longint'(raw) % 256;
      MEM_LHU: v = longint'(raw) % 65536;
      default: v = longint'(raw);
    endcase
    return v[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic check_cycle();
    int rel;
    bit exp_req, exp_stall, exp_wbv;
    rel       = cyc - t0;
    exp_req   = active && is_mem && rel >= 1 && xq.size() > 0;
    exp_stall = active && is_mem && (rel == 0 || xq.size() > 0 || (is_ld && cyc == last_g + 1));
    if (stall_req_o) stall_seen = 1;
    chk("stall_req", 32'(stall_req_o), 32'(exp_stall));
    chk("mem_req", 32'(mem_req_o), 32'(exp_req));
    rd_pend = 0;
    if (exp_req) begin
      chk("mem_a", mem_a_o, xq[0].a);
      chk("mem_we", 32'(mem_we_o), 32'(xq[0].we));
      chk("mem_dout", 32'(mem_dout_o), 32'(xq[0].d));
      if (mem_gnt_i) begin
        if (obs_n < 8) begin
          obs_a[obs_n] = mem_a_o; obs_d[obs_n] = mem_dout_o; obs_rel[obs_n] = rel;
          obs_n++;
        end
        if (mem_we_o) mem[mem_a_o] = mem_dout_o;
        else begin rd_pend = 1; rd_pend_addr = mem_a_o; end
        last_g = cyc;
        void'(xq.pop_front());
        if (xq.size() == 0) wb_cyc = cyc + (is_ld ? 2 : 1);
      end
    end
    exp_wbv = active && cyc == wb_cyc;
    chk("wb_valid", 32'(wb_valid_o), 32'(exp_wbv));
    if (exp_wbv) begin
      chk("wb_rd_en", 32'(wb_rd_en_o), 32'(exp_wb_en));
      if (!is_mem || is_ld) begin
        chk("wb_rd_addr", 32'(wb_rd_addr_o), 32'(exp_wb_rd));
        chk("wb_data", wb_data_o, exp_wb_data);
      end
      obs_wb_rel = rel; obs_wb_data = wb_data_o; obs_wb_en = wb_rd_en_o; obs_wb_rd = wb_rd_addr_o;
      active = 0;
    end else begin
      chk("wb_idle_data", wb_data_o, 32'd0);
      chk("wb_idle_rd", 32'({wb_rd_en_o, wb_rd_addr_o}), 32'd0);
    end
  endtask

  task automatic drive_bus();
    case (gmode)
      0:       mem_gnt_i = 1'b1;
      1:       mem_gnt_i = ($urandom_range(3) != 0);
      2:       mem_gnt_i = ((cyc - t0) % 2 == 1);
      default: mem_gnt_i = 1'($urandom_range(1));
    endcase
    mem_din_i = rd_pend ? mem_rd(rd_pend_addr) : 8'($urandom);
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    cyc++;
    #1;
    drive_bus();
  endtask

  task automatic begin_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] wd,
                          input logic [4:0] rd, input logic rden, input logic [31:0] rdata,
                          input int gm);
    logic [31:0] raw;
    int n;
    gmode = gm; t0 = cyc; active = 1; last_g = -10; obs_n = 0; obs_wb_rel = -1;
    stall_seen = 0; xq.delete();
    n = nb(op); is_mem = (n != 0); is_ld = op_load(op);
    raw = 32'd0;
    for (int j = 0; j < n; j++) begin
      xfer_t x;
      x.a  = a + 32'(j);
      x.we = !is_ld;
      x.d  = is_ld ? 8'h00 : wd[8*j +: 8];
      raw[8*j +: 8] = mem_rd(x.a);
      xq.push_back(x);
    end
    exp_wb_rd = rd;
    if (!is_mem) begin
      wb_cyc = cyc + 1; exp_wb_en = rden; exp_wb_data = rdata;
    end else begin
      wb_cyc = -1; exp_wb_en = is_ld ? rden : 1'b0; exp_wb_data = ext_model(op, raw);
    end
    valid_i = 1'b1; op_i = op; addr_i = a; wdata_i = wd;
    rd_addr_i = rd; rd_en_i = rden; rd_data_i = rdata;
  endtask

  // The EX/MEM latch holds its contents while stalled, including the DONE cycle
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] rd, input logic rden, input logic [31:0] rdata,
                        input int gm);
    int guard;
    begin_op(op, a, wd, rd, rden, rdata, gm);
    step();
    if (!is_mem) valid_i = 1'b0;
    guard = 0;
    while (active && guard < 100) begin
      step();
      guard++;
    end
    checks++;
    if (active) begin
      failures++;
      $display("FAIL op_complete actual=timeout required=writeback op=%0d", op);
      active = 0;
    end
    valid_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctl"}, 32'({mem_req_o, mem_we_o, stall_req_o, wb_valid_o, wb_rd_en_o}), 32'd0);
    chk({tag, "_mem_a"}, mem_a_o, 32'd0);
    chk({tag, "_dout_rd"}, 32'({mem_dout_o, wb_rd_addr_o}), 32'd0);
    chk({tag, "_wb_data"}, wb_data_o, 32'd0);
  endtask

  logic [4:0] ops[9];

  initial begin
    rst = 1'b1; valid_i = 1'b0; op_i = 5'd0; addr_i = 32'd0; wdata_i = 32'd0;
    rd_addr_i = 5'd0; rd_en_i = 1'b0; rd_data_i = 32'd0; mem_gnt_i = 1'b0; mem_din_i = 8'd0;
    active = 0; gmode = 0; t0 = 0; rd_pend = 0;
    ops = '{MEM_NONE, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW};
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // LW little-endian assembly and T6 write-back
    mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33; mem[32'h103] = 8'h84;
    run_op(MEM_LW, 32'h100, 32'd0, 5'd5, 1'b1, 32'd0, 0);
    chk("lw_data", obs_wb_data, 32'h84332211);
    chk("lw_wb_rel", 32'(obs_wb_rel), 32'd6);
    for (int j = 0; j < 4; j++) begin
      chk("lw_addr", obs_a[j], 32'h100 + 32'(j));
      chk("lw_req_rel", 32'(obs_rel[j]), 32'(j + 1));
    end

    // Sign vs zero extension of byte 0x80
    mem[32'h2003] = 8'h80;
    run_op(MEM_LB, 32'h2003, 32'd0, 5'd3, 1'b1, 32'd0, 0);
    chk("lb_data", obs_wb_data, 32'hFFFFFF80);
    run_op(MEM_LBU, 32'h2003, 32'd0, 5'd3, 1'b1, 32'd0, 1);
    chk("lbu_data", obs_wb_data, 32'h00000080);

    // SH at an odd address
    run_op(MEM_SH, 32'h201, 32'hABCD1234, 5'd9, 1'b1, 32'd0, 0);
    chk("sh_a0", obs_a[0], 32'h201); chk("sh_d0", 32'(obs_d[0]), 32'h34); chk("sh_r0", 32'(obs_rel[0]), 32'd1);
    chk("sh_a1", obs_a[1], 32'h202); chk("sh_d1", 32'(obs_d[1]), 32'h12); chk("sh_r1", 32'(obs_rel[1]), 32'd2);
    chk("sh_wb_rel", 32'(obs_wb_rel), 32'd3);
    chk("sh_rd_en", 32'(obs_wb_en), 32'd0);

    // SW wrapping past the top of memory with alternating grant
    run_op(MEM_SW, 32'hFFFFFFFE, 32'hDEADBEEF, 5'd4, 1'b0, 32'd0, 2);
    chk("sw_a0", obs_a[0], 32'hFFFFFFFE); chk("sw_a1", obs_a[1], 32'hFFFFFFFF);
    chk("sw_a2", obs_a[2], 32'h0);        chk("sw_a3", obs_a[3], 32'h1);
    chk("sw_mem", {mem_rd(32'h1), mem_rd(32'h0), mem_rd(32'hFFFFFFFF), mem_rd(32'hFFFFFFFE)}, 32'hDEADBEEF);
    chk("sw_wb_rel", 32'(obs_wb_rel), 32'd8);

    // Non-memory op
    run_op(MEM_NONE, 32'h0, 32'd0, 5'd7, 1'b1, 32'h5, 0);
    chk("add_wb", {obs_wb_data[26:0], obs_wb_en, obs_wb_rd}, {27'h5, 1'b1, 5'd7});
    chk("add_wb_rel", 32'(obs_wb_rel), 32'd1);
    chk("add_no_stall", 32'(stall_seen), 32'd0);

    // Reset in T2 of an LW aborts it
    begin_op(MEM_LW, 32'h100, 32'd0, 5'd6, 1'b1, 32'd0, 0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; valid_i = 1'b0; active = 0; xq.delete();
    #1;
    check_all_zero("abort");
    repeat (4) step();
    run_op(MEM_LW, 32'h100, 32'd0, 5'd6, 1'b1, 32'd0, 0);
    chk("after_abort_lw", obs_wb_data, 32'h84332211);

    // Randomized ops, grant patterns and addresses (some wrapping)
    repeat (60) begin
      logic [31:0] a;
      a = ($urandom_range(7) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(3))
                                   : 32'h3000 + 32'($urandom_range(63));
      run_op(ops[$urandom_range(8)], a, $urandom, 5'($urandom), 1'($urandom_range(1)),
             $urandom, int'($urandom_range(3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
